sim_ram_arbiter: RTL

Shares one SimRAM instance (separate read and write ports, 1-cycle read latency) between NUM_REQ requesters, e.g. instruction fetch, load/store unit and debug port.
- Each cycle it grants at most one read and one write, using independent round-robin pointers.
- It guarantees the RAM never sees a read and a write to the same word in the same cycle.
- It routes each read response back to the requester that issued it.

---
 rtl/sim_ram_arb_pkg.sv | 23 ++
 rtl/sim_ram_arbiter_rr_pick.sv | 41 ++++
 rtl/sim_ram_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sim_ram_arb_pkg.sv
// ============================================================================
// Module  : sim_ram_arb_pkg
// Brief   : Shared types, constants and helpers for the SimRAM arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package sim_ram_arb_pkg;

  // Index wide enough for the largest supported requester count (8)
  localparam int c_IDX_W = 3;
  typedef logic [c_IDX_W-1:0] req_idx_t;

  localparam logic c_OP_READ  = 1'b0;
  localparam logic c_OP_WRITE = 1'b1;

  function automatic int calc_aw(input int addr_width, input int data_size);
    return addr_width - $clog2(data_size);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sim_ram_arbiter_rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Round-robin first-one finder: first set bit scanning from ptr.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick
  import sim_ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           ptr,
  output logic               found,
  output req_idx_t           idx
);

  int w_best;
  int w_dist;

  // Smallest circular distance from ptr wins
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    w_best = NUM_REQ;
    w_dist = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = i - int'(ptr);
      if (w_dist < 0) w_dist = w_dist + NUM_REQ;
      if (req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        found  = 1'b1;
        idx    = req_idx_t'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sim_ram_arbiter.sv
// ============================================================================
// Module  : sim_ram_arbiter
// Brief   : Shares one SimRAM between NUM_REQ requesters, one read and one
//           write per cycle, with same-word read/write conflict avoidance.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sim_ram_arbiter
  import sim_ram_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 2,
  parameter  int DATA_SIZE  = 4,
  parameter  int ADDR_WIDTH = 16,
  parameter  int CNT_WIDTH  = 16,
  localparam int AW         = calc_aw(ADDR_WIDTH, DATA_SIZE),
  localparam int DW         = 8 * DATA_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [DW-1:0]         resp_rdata,
  output logic                  ram_rd_en,
  output logic [AW-1:0]         ram_rd_addr,
  output logic                  ram_wr_en,
  output logic [AW-1:0]         ram_wr_addr,
  output logic [DW-1:0]         ram_wr_data,
  input  logic [DW-1:0]         ram_rd_data,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  localparam req_idx_t c_LAST = req_idx_t'(NUM_REQ - 1);

  req_idx_t             r_rd_ptr;
  req_idx_t             r_wr_ptr;
  logic [NUM_REQ-1:0]   r_resp_valid;
  logic [CNT_WIDTH-1:0] r_conflict_cnt;

  logic [NUM_REQ-1:0]   w_wr_cand;
  logic [NUM_REQ-1:0]   w_rd_cand;
  logic                 w_wr_found;
  logic                 w_rd_found;
  req_idx_t             w_wr_idx;
  req_idx_t             w_rd_idx;
  logic [AW-1:0]        w_wr_addr;
  logic [DW-1:0]        w_wr_data;
  logic [AW-1:0]        w_rd_addr;
  logic                 w_conflict;
  logic                 w_wr_grant;
  logic                 w_rd_grant;
  logic [NUM_REQ-1:0]   w_ready;
  logic [NUM_REQ-1:0]   w_rd_onehot;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign w_wr_cand[gi]   = req_valid[gi] && (req_we[gi] == c_OP_WRITE);
    assign w_rd_cand[gi]   = req_valid[gi] && (req_we[gi] == c_OP_READ);
    assign w_rd_onehot[gi] = w_rd_grant && (w_rd_idx == req_idx_t'(gi));
    assign w_ready[gi]     = w_rd_onehot[gi] ||
                             (w_wr_grant && (w_wr_idx == req_idx_t'(gi)));
  end

  rr_pick #(.NUM_REQ(NUM_REQ)) u_wr_pick (
    .req   (w_wr_cand),
    .ptr   (r_wr_ptr),
    .found (w_wr_found),
    .idx   (w_wr_idx)
  );

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rd_pick (
    .req   (w_rd_cand),
    .ptr   (r_rd_ptr),
    .found (w_rd_found),
    .idx   (w_rd_idx)
  );

  always_comb begin
    w_wr_addr = '0;
    w_wr_data = '0;
    w_rd_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_wr_idx == req_idx_t'(i)) begin
        w_wr_addr = req_addr[i*AW +: AW];
        w_wr_data = req_wdata[i*DW +: DW];
      end
      if (w_rd_idx == req_idx_t'(i)) begin
        w_rd_addr = req_addr[i*AW +: AW];
      end
    end
  end

  // Same-word collision: the write wins and no other read is substituted
  assign w_conflict = w_wr_found && w_rd_found && (w_wr_addr == w_rd_addr);
  assign w_wr_grant = w_wr_found;
  assign w_rd_grant = w_rd_found && !w_conflict;

  assign req_ready    = w_ready & {NUM_REQ{rst_n}};
  assign ram_wr_en    = w_wr_grant && rst_n;
  assign ram_rd_en    = w_rd_grant && rst_n;
  assign ram_wr_addr  = w_wr_addr;
  assign ram_wr_data  = w_wr_data;
  assign ram_rd_addr  = w_rd_addr;
  assign resp_valid   = r_resp_valid;
  assign resp_rdata   = ram_rd_data;
  assign conflict_cnt = r_conflict_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_resp_valid   <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_wr_grant) begin
        r_wr_ptr <= (w_wr_idx == c_LAST) ? '0 : w_wr_idx + req_idx_t'(1);
      end
      if (w_rd_grant) begin
        r_rd_ptr <= (w_rd_idx == c_LAST) ? '0 : w_rd_idx + req_idx_t'(1);
      end
      // Read data arrives one cycle after the grant; the tag rides along here
      r_resp_valid <= w_rd_onehot;
      if (w_conflict && (r_conflict_cnt != {CNT_WIDTH{1'b1}})) begin
        r_conflict_cnt <= r_conflict_cnt + 1'b1;
      end
    end
  end

  a_no_same_word : assert property (@(posedge clk) disable iff (!rst_n)
    !(ram_rd_en && ram_wr_en && (ram_rd_addr == ram_wr_addr)));

endmodule

`default_nettype wire
